board_mem: RTL and testbench

- Parametrised game-board cell memory; successor to the single-port 2-bit tristate board RAM.
- Separate write/read data buses replace the tristate bus. Adds a game-logic port, an independent VGA read port and a hardware clear sequencer.
- Adds a running count of cells holding MARK_VAL, e.g. remaining ship cells.
- Sits between game FSM and VGA pixel generator.

---
 rtl/battleship_pkg.sv | 25 ++
 rtl/board_clear_seq.sv | 68 ++++++
 rtl/board_mem.sv | 118 +++++++++++
 tb/tb_board_mem.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// Shared board definitions: geometry, cell encodings and the clear-sequencer states.
// Imported by the board memory and its clear sequencer.
package battleship_pkg;

  localparam int BOARD_ROWS   = 10;
  localparam int BOARD_COLS   = 10;
  localparam int BOARD_DEPTH  = BOARD_ROWS * BOARD_COLS;
  localparam int BOARD_ADDR_W = 7;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_MISS  = 2'b01;
  localparam logic [1:0] CELL_HIT   = 2'b10;
  localparam logic [1:0] CELL_SHIP  = 2'b11;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } clr_state_e;

  // Linear cell address of (row, col) on the default board.
  function automatic logic [BOARD_ADDR_W-1:0] cell_addr(input int row, input int col);
    return BOARD_ADDR_W'(row * BOARD_COLS + col);
  endfunction

endpackage

// File: rtl/board_clear_seq.sv
// Clear sequencer: walks a pointer over every cell, one write per cycle,
// starting automatically out of reset and again on each accepted clr pulse.
module board_clear_seq
  import battleship_pkg::*;
#(
  parameter int DEPTH  = BOARD_DEPTH,
  parameter int ADDR_W = BOARD_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              busy,
  output logic              done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_last
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  clr_state_e        state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic              done_reg, done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_CLEAR;
      ptr_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    done_next  = 1'b0;
    clr_last   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (clr) begin
          state_next = S_CLEAR;
          ptr_next   = '0;
        end
      end
      S_CLEAR: begin
        // The final cell is written on the same cycle we leave the state.
        if (ptr_reg == LAST_PTR) begin
          clr_last   = 1'b1;
          done_next  = 1'b1;
          state_next = S_IDLE;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr_reg + ADDR_W'(1);
        end
      end
    endcase
  end

  assign busy     = (state_reg == S_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = ptr_reg;
  assign done     = done_reg;

endmodule

// File: rtl/board_mem.sv
// Game-board cell memory with a game read/write port, an independent VGA read
// port, a hardware clear sequencer and a running count of MARK_VAL cells.
module board_mem
  import battleship_pkg::*;
#(
  parameter int                DATA_W   = 2,
  parameter int                ROWS     = BOARD_ROWS,
  parameter int                COLS     = BOARD_COLS,
  parameter int                DEPTH    = ROWS * COLS,
  parameter int                ADDR_W   = BOARD_ADDR_W,
  parameter logic [DATA_W-1:0] CLR_VAL  = CELL_EMPTY,
  parameter logic [DATA_W-1:0] MARK_VAL = CELL_SHIP,
  parameter int                CNT_W    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              oe,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  input  logic              clr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  mark_cnt
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we, clr_last;
  logic [ADDR_W-1:0] clr_addr;

  logic              addr_ok, vga_ok;
  logic              game_wr, game_rd, err_next;
  logic [DATA_W-1:0] old_cell;

  logic [DATA_W-1:0] rdata_reg, vga_data_reg;
  logic              rvalid_reg, err_reg;
  logic [CNT_W-1:0]  mark_reg, mark_next;

  board_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .busy     (busy),
    .done     (done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .clr_last (clr_last)
  );

  assign addr_ok  = (addr < DEPTH_A);
  assign vga_ok   = (vga_addr < DEPTH_A);
  assign game_wr  = we && addr_ok && !busy;
  assign game_rd  = oe && !we && addr_ok && !busy;
  // Any game-port access that is out of range or arrives during a clear is rejected.
  assign err_next = (we || oe) && (!addr_ok || busy);
  assign old_cell = addr_ok ? mem[addr] : CLR_VAL;

  // Storage carries no reset; the clear sequencer defines its contents.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= CLR_VAL;
    end else if (game_wr) begin
      mem[addr] <= wdata;
    end
  end

  always_comb begin
    mark_next = mark_reg;
    if (clr_last) begin
      mark_next = (CLR_VAL == MARK_VAL) ? CNT_MAX : '0;
    end else if (game_wr) begin
      if (old_cell != MARK_VAL && wdata == MARK_VAL && mark_reg != CNT_MAX) begin
        mark_next = mark_reg + CNT_W'(1);
      end else if (old_cell == MARK_VAL && wdata != MARK_VAL && mark_reg != '0) begin
        mark_next = mark_reg - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg    <= '0;
      rvalid_reg   <= 1'b0;
      vga_data_reg <= '0;
      err_reg      <= 1'b0;
      mark_reg     <= '0;
    end else begin
      if (game_rd) begin
        rdata_reg <= mem[addr];
      end
      rvalid_reg   <= game_rd;
      vga_data_reg <= vga_ok ? mem[vga_addr] : CLR_VAL;
      err_reg      <= err_next;
      mark_reg     <= mark_next;
    end
  end

  assign rdata    = rdata_reg;
  assign rvalid   = rvalid_reg;
  assign vga_data = vga_data_reg;
  assign err      = err_reg;
  assign mark_cnt = mark_reg;

  mark_cnt_bounded: assert property (@(posedge clk) disable iff (!rst_n) mark_reg <= CNT_MAX);

endmodule

// File: tb/tb_board_mem.sv
// Directed bench for board_mem: reset clear, game reads/writes, mark counting,
// error pulses, clear while busy, reset abort and a VGA sweep.
module tb_board_mem;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       we, oe, clr;
  logic [6:0] addr, vga_addr;
  logic [1:0] wdata;
  logic [1:0] rdata, vga_data;
  logic       rvalid, busy, done, err;
  logic [6:0] mark_cnt;

  int vectors = 0;
  int miscompares = 0;
  int n;

  always #5 clk = ~clk;

  board_mem dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .oe       (oe),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .vga_addr (vga_addr),
    .vga_data (vga_data),
    .clr      (clr),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mark_cnt (mark_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle game write; checks the counter after the edge.
  task automatic wr(input logic [6:0] a, input logic [1:0] d, input logic [6:0] exp_cnt);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
    chk($sformatf("wr_err_%0h", a), err, 0);
    chk($sformatf("wr_cnt_%0h", a), mark_cnt, exp_cnt);
  endtask

  task automatic rd(input logic [6:0] a, input logic [1:0] exp_d);
    oe = 1'b1; addr = a;
    @(negedge clk);
    oe = 1'b0;
    chk($sformatf("rd_rvalid_%0h", a), rvalid, 1);
    chk($sformatf("rd_data_%0h", a), rdata, exp_d);
  endtask

  // Counts cycles with busy high, starting from the current sample.
  task automatic wait_clear(input string tag);
    n = 0;
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, n, 100);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_cnt"}, mark_cnt, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; oe = 1'b0; clr = 1'b0;
    addr = '0; vga_addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_vga", vga_data, 0);
    chk("rst_err", err, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", mark_cnt, 0);

    rst_n = 1'b1;
    #1;
    wait_clear("boot");
    rd(7'h63, 2'b00);
    @(negedge clk);
    chk("rvalid_single", rvalid, 0);
    chk("rdata_hold", rdata, 2'b00);

    wr(7'h00, 2'b00, 0);
    wr(7'h09, 2'b01, 0);
    wr(7'h02, 2'b10, 0);
    wr(7'h17, 2'b11, 1);
    rd(7'h00, 2'b00);
    rd(7'h09, 2'b01);
    rd(7'h02, 2'b10);
    rd(7'h17, 2'b11);

    wr(7'h17, 2'b11, 1);
    wr(7'h17, 2'b10, 0);
    rd(7'h17, 2'b10);
    vga_addr = 7'h20;
    wr(7'h20, 2'b11, 1);
    chk("vga_old", vga_data, 2'b00);
    @(negedge clk);
    chk("vga_new", vga_data, 2'b11);
    wr(7'h21, 2'b11, 2);
    wr(7'h21, 2'b11, 2);

    // Write and read together: the write wins silently.
    we = 1'b1; oe = 1'b1; addr = 7'h09; wdata = 2'b10;
    @(negedge clk);
    we = 1'b0; oe = 1'b0;
    chk("we_oe_rvalid", rvalid, 0);
    chk("we_oe_err", err, 0);
    rd(7'h09, 2'b10);

    we = 1'b1; addr = 7'h64; wdata = 2'b11;
    @(negedge clk);
    we = 1'b0;
    chk("oor_wr_err", err, 1);
    chk("oor_wr_rvalid", rvalid, 0);
    chk("oor_wr_cnt", mark_cnt, 2);
    oe = 1'b1; addr = 7'h7F;
    @(negedge clk);
    oe = 1'b0;
    chk("oor_rd_err", err, 1);
    chk("oor_rd_rvalid", rvalid, 0);
    @(negedge clk);
    chk("err_pulse_end", err, 0);
    rd(7'h21, 2'b11);

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_busy", busy, 1);
    n = 0;
    while (busy && n < 300) begin
      n++;
      we  = (n == 10);
      addr = 7'h05; wdata = 2'b11;
      clr = (n == 30);
      @(negedge clk);
      if (n == 10) chk("busy_wr_err", err, 1);
    end
    we = 1'b0; clr = 1'b0;
    chk("clr_busy_cycles", n, 100);
    chk("clr_done", done, 1);
    chk("clr_cnt", mark_cnt, 0);
    @(negedge clk);
    chk("clr_done_pulse", done, 0);
    rd(7'h05, 2'b00);
    rd(7'h17, 2'b00);
    rd(7'h21, 2'b00);

    wr(7'h30, 2'b11, 1);
    wr(7'h60, 2'b01, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1);
    chk("abort_cnt", mark_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_release_busy", busy, 1);
    wait_clear("abort");

    for (int a = 0; a < 100; a++) begin
      vga_addr = 7'(a);
      @(negedge clk);
      chk($sformatf("vga_%0h", a), vga_data, 2'b00);
    end
    wr(7'h10, 2'b10, 0);
    vga_addr = 7'h10;
    @(negedge clk);
    chk("vga_10", vga_data, 2'b10);
    vga_addr = 7'h7F;
    @(negedge clk);
    chk("vga_7f", vga_data, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
